// File: rtl/move_ctrl.sv
// move_ctrl: input sequencer in front of the game FSM. It turns raw
// direction and restart buttons into clean single-cycle commands.
//
// Ports:
//   clk      system clock, all logic on rising edge
//   rst      asynchronous active-low reset
//   btn      raw direction buttons [0]up [1]down [2]left [3]right
//   btn_rst  raw restart button
//   game_s   game FSM state: 00 idle, 01 playing, 10 win, 11 over
//   ste_num  current step count from the game FSM
//   active   one-cycle move command
//   reset    one-cycle restart command
//   dir      direction of the last issued move
//   limit    high while ste_num >= MAX_STEP (registered)
module move_ctrl #(
    parameter int DB_CNT   = 1_000_000,
    parameter int DB_W     = 20,
    parameter int MAX_STEP = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       btn_rst,
    input  logic [1:0] game_s,
    input  logic [5:0] ste_num,
    output logic       active,
    output logic       reset,
    output logic [1:0] dir,
    output logic       limit
);

    typedef enum logic [1:0] {
        IDLE,
        READY,
        ISSUE,
        HOLD
    } state_t;

    localparam logic [DB_W-1:0] CNT_TOP = DB_W'(DB_CNT - 1);
    localparam logic [5:0]      LIM     = 6'(MAX_STEP);

    state_t     state;
    state_t     state_n;
    logic [4:0] raw;
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] db;
    logic [4:0] db_q;
    logic [4:0] rise;
    logic [3:0] mv_rise;
    logic       rst_rise;
    logic       mv_ok;
    logic       dir_ld;
    logic [1:0] dir_pick;

    assign raw = {btn_rst, btn};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level only flips after DB_CNT consecutive cycles of disagreement
    // with the synchronised input; any agreement restarts the count.
    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_TOP) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign db[i] = lvl;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q  <= '0;
            limit <= 1'b0;
            reset <= 1'b0;
        end else begin
            db_q  <= db;
            limit <= (ste_num >= LIM);
            reset <= rise[4];
        end
    end

    assign rise     = db & ~db_q;
    assign mv_rise  = rise[3:0];
    assign rst_rise = rise[4];
    assign mv_ok    = (game_s == 2'b01) && !limit;

    // Simultaneous rises resolve up > down > left > right.
    always_comb begin
        dir_pick = 2'd0;
        priority case (1'b1)
            mv_rise[0]: dir_pick = 2'd0;
            mv_rise[1]: dir_pick = 2'd1;
            mv_rise[2]: dir_pick = 2'd2;
            mv_rise[3]: dir_pick = 2'd3;
            default:    dir_pick = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Restart overrides everything, including a move about to issue,
    // so active and reset can never be high in the same cycle.
    always_comb begin
        state_n = state;
        dir_ld  = 1'b0;
        active  = (state == ISSUE);
        if (rst_rise) begin
            state_n = HOLD;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mv_ok) state_n = READY;
                end
                READY: begin
                    if (!mv_ok) begin
                        state_n = IDLE;
                    end else if (|mv_rise) begin
                        state_n = ISSUE;
                        dir_ld  = 1'b1;
                    end
                end
                ISSUE: begin
                    state_n = HOLD;
                end
                HOLD: begin
                    if (~|db[3:0]) state_n = mv_ok ? READY : IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir <= 2'd0;
        end else if (dir_ld) begin
            dir <= dir_pick;
        end
    end

endmodule
